// File: rtl/led_row_scan_scheduler_if.sv
// Panel-side bundle for the HUB75E row scan scheduler: decoder handshake, controls, panel pins.
// The master modport is the scheduler; the slave modport is the decoder/pin-driver environment.
interface led_row_scan_scheduler_if #(
    parameter int unsigned BRIGHT_W = 8
);
    logic                in_enable;
    logic [BRIGHT_W-1:0] in_brightness;
    logic                pix_valid;
    logic                pix_rdy;
    logic                led_clk;
    logic                led_lat;
    logic                led_oe;
    logic [4:0]          led_row;
    logic                frame_start;

    modport master (
        input  in_enable,
        input  in_brightness,
        input  pix_valid,
        output pix_rdy,
        output led_clk,
        output led_lat,
        output led_oe,
        output led_row,
        output frame_start
    );

    modport slave (
        output in_enable,
        output in_brightness,
        output pix_valid,
        input  pix_rdy,
        input  led_clk,
        input  led_lat,
        input  led_oe,
        input  led_row,
        input  frame_start
    );
endinterface

// File: rtl/led_row_scan_scheduler.sv
// HUB75E row scan scheduler: shifts one row, blanks, latches, advances row, displays while next shifts.
// Optional LED_DISPLAY_STRETCH_EN scales the per-row display time by 4.
module led_row_scan_scheduler #(
    parameter int unsigned PIXEL_COUNT = 64,
    parameter int unsigned ROW_COUNT   = 8,
    parameter int unsigned BRIGHT_W    = 8,
    parameter int unsigned PRE_BLANK   = 2,
    parameter int unsigned POST_BLANK  = 2
) (
    input logic                       in_clk,
    input logic                       in_nrst,
    led_row_scan_scheduler_if.master  bus
);

    localparam int unsigned PixW     = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
    localparam int unsigned BlankMax = (PRE_BLANK > POST_BLANK) ? PRE_BLANK : POST_BLANK;
    localparam int unsigned BlankW   = $clog2(BlankMax + 1);
`ifdef LED_DISPLAY_STRETCH_EN
    localparam int unsigned TimerW   = BRIGHT_W + 2;
`else
    localparam int unsigned TimerW   = BRIGHT_W;
`endif

    localparam logic [PixW-1:0]   PixLast  = PixW'(PIXEL_COUNT - 1);
    localparam logic [BlankW-1:0] PreLast  = BlankW'(PRE_BLANK - 1);
    localparam logic [BlankW-1:0] PostLast = BlankW'(POST_BLANK - 1);
    localparam logic [4:0]        RowLast  = 5'(ROW_COUNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StWaitDisp,
        StPre,
        StLatch,
        StPost
    } state_e;

    state_e              state_q;
    logic [PixW-1:0]     pix_cnt_q;
    logic [BlankW-1:0]   blank_cnt_q;
    logic [TimerW-1:0]   timer_q;
    logic [TimerW-1:0]   timer_d;
    logic [TimerW-1:0]   disp_load;
    logic                led_clk_q;
    logic                led_lat_q;
    logic                led_oe_q;
    logic [4:0]          led_row_q;
    logic                frame_start_q;
    logic                accept;
    logic                post_exit;

    assign bus.pix_rdy     = (state_q == StShift);
    assign bus.led_clk     = led_clk_q;
    assign bus.led_lat     = led_lat_q;
    assign bus.led_oe      = led_oe_q;
    assign bus.led_row     = led_row_q;
    assign bus.frame_start = frame_start_q;

    assign accept    = bus.pix_valid & (state_q == StShift);
    assign post_exit = (state_q == StPost) && (blank_cnt_q == PostLast);

`ifdef LED_DISPLAY_STRETCH_EN
    assign disp_load = {bus.in_brightness, 2'b00};
`else
    assign disp_load = bus.in_brightness;
`endif

    // Display timer: reloaded when a new row starts shifting, otherwise counts down to zero.
    always_comb begin
        timer_d = timer_q;
        if (post_exit && bus.in_enable) begin
            timer_d = disp_load;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TimerW'(1);
        end
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state_q       <= StIdle;
            pix_cnt_q     <= '0;
            blank_cnt_q   <= '0;
            timer_q       <= '0;
            led_clk_q     <= 1'b0;
            led_lat_q     <= 1'b0;
            led_oe_q      <= 1'b0;
            led_row_q     <= RowLast;
            frame_start_q <= 1'b0;
        end else begin
            led_clk_q     <= accept;
            led_lat_q     <= 1'b0;
            frame_start_q <= 1'b0;
            timer_q       <= timer_d;
            // OE mirrors the timer; the timer is only non-zero in SHIFT and WAIT_DISP.
            led_oe_q      <= (timer_d != '0);

            case (state_q)
                StIdle: begin
                    pix_cnt_q <= '0;
                    if (bus.in_enable) begin
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    if (accept) begin
                        if (pix_cnt_q == PixLast) begin
                            pix_cnt_q <= '0;
                            state_q   <= StWaitDisp;
                        end else begin
                            pix_cnt_q <= pix_cnt_q + PixW'(1);
                        end
                    end
                end
                StWaitDisp: begin
                    // Leave as soon as the previous row's display time has run out.
                    if (timer_d == '0) begin
                        blank_cnt_q <= '0;
                        state_q     <= StPre;
                    end
                end
                StPre: begin
                    if (blank_cnt_q == PreLast) begin
                        blank_cnt_q <= '0;
                        led_lat_q   <= 1'b1;
                        state_q     <= StLatch;
                    end else begin
                        blank_cnt_q <= blank_cnt_q + BlankW'(1);
                    end
                end
                StLatch: begin
                    if (led_row_q == RowLast) begin
                        led_row_q     <= '0;
                        frame_start_q <= 1'b1;
                    end else begin
                        led_row_q <= led_row_q + 5'd1;
                    end
                    blank_cnt_q <= '0;
                    state_q     <= StPost;
                end
                StPost: begin
                    if (blank_cnt_q == PostLast) begin
                        blank_cnt_q <= '0;
                        state_q     <= bus.in_enable ? StShift : StIdle;
                    end else begin
                        blank_cnt_q <= blank_cnt_q + BlankW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_row_scan_scheduler.sv
// Scoreboard bench for led_row_scan_scheduler: per-row expectations queued by stimulus,
// checked by a negedge monitor against panel timing rules.
module tb_led_row_scan_scheduler;

    localparam int PIXEL_COUNT = 64;
    localparam int ROW_COUNT   = 8;
    localparam int BRIGHT_W    = 8;
    localparam int PRE_BLANK   = 2;
    localparam int POST_BLANK  = 2;
    localparam int BUDGET      = 4000;

    logic in_clk;
    logic in_nrst;

    led_row_scan_scheduler_if #(.BRIGHT_W(BRIGHT_W)) bus ();

    led_row_scan_scheduler #(
        .PIXEL_COUNT (PIXEL_COUNT),
        .ROW_COUNT   (ROW_COUNT),
        .BRIGHT_W    (BRIGHT_W),
        .PRE_BLANK   (PRE_BLANK),
        .POST_BLANK  (POST_BLANK)
    ) dut (
        .in_clk  (in_clk),
        .in_nrst (in_nrst),
        .bus     (bus)
    );

    typedef struct {
        int row;
        int fs;
        int oe;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int n_checks = 0;
    int n_errors = 0;
    int pv_mode  = 0;
    int model_row;

    // Monitor state
    int cyc = 0;
    int clk_cnt = 0;
    int oe_cnt = 0;
    int clk_total = 0;
    int lat_total = 0;
    int last_clk = 0;
    int last_oe = 0;
    int last_lat = 0;
    int lat_seen = 0;
    int lat_prev = 0;
    int pv_prev = 0;
    int check_next = 0;
    int fs_stray = 0;

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int disp_of(input int br);
`ifdef LED_DISPLAY_STRETCH_EN
        return br * 4;
`else
        return br;
`endif
    endfunction

    // pix_valid driver: 0 = always valid, 1 = toggling, 2 = random
    initial begin
        bus.pix_valid = 1'b0;
        forever begin
            @(posedge in_clk);
            #1;
            if (pv_mode == 0) bus.pix_valid = 1'b1;
            else if (pv_mode == 1) bus.pix_valid = ~bus.pix_valid;
            else bus.pix_valid = 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge in_clk);
            if (!in_nrst) begin
                clk_cnt = 0; oe_cnt = 0; lat_seen = 0; lat_prev = 0;
                pv_prev = 0; check_next = 0; last_clk = cyc; last_oe = cyc;
            end else begin
                cyc++;
                if (bus.led_clk) begin
                    check("led_clk_without_accept", pv_prev, 1);
                    clk_cnt++; clk_total++; last_clk = cyc;
                end
                if (bus.led_oe) begin
                    if (oe_cnt == 0 && lat_seen != 0)
                        check("oe_start_after_lat", cyc - last_lat, POST_BLANK + 1);
                    if (bus.led_lat) check("lat_during_oe", 1, 0);
                    oe_cnt++; last_oe = cyc;
                end
                if (check_next != 0) begin
                    check("led_row", int'(bus.led_row), cur.row);
                    check("frame_start", int'(bus.frame_start), cur.fs);
                    check_next = 0;
                end else if (bus.frame_start) begin
                    fs_stray++;
                end
                if (bus.led_lat) begin
                    lat_total++;
                    check("lat_width", lat_prev, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_lat", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("clk_per_row", clk_cnt, PIXEL_COUNT);
                        check("oe_cycles", oe_cnt, cur.oe);
                        check("lat_timing", cyc,
                              ((oe_cnt > 0 && last_oe > last_clk) ? last_oe : last_clk)
                              + PRE_BLANK + 1);
                        check_next = 1;
                    end
                    clk_cnt = 0; oe_cnt = 0; last_lat = cyc; lat_seen = 1;
                end
                lat_prev = int'(bus.led_lat);
                pv_prev  = int'(bus.pix_valid);
            end
        end
    end

    task automatic wait_lats(input int k);
        int target = lat_total + k;
        int n = 0;
        while (lat_total < target && n < BUDGET * k) begin
            @(negedge in_clk); #1; n++;
        end
        if (lat_total < target) check("lat_wait_timeout", lat_total, target);
    endtask

    task automatic wait_clks(input int k);
        int target = clk_total + k;
        int n = 0;
        while (clk_total < target && n < BUDGET) begin
            @(negedge in_clk); #1; n++;
        end
        if (clk_total < target) check("clk_wait_timeout", clk_total, target);
    endtask

    task automatic run_rows(input int n, input int br, input int md);
        exp_t e;
        int r;
        pv_mode = md;
        bus.in_brightness = BRIGHT_W'(br);
        for (int i = 0; i < n; i++) begin
            model_row = (model_row + 1) % ROW_COUNT;
            e.row = model_row;
            e.fs  = (model_row == 0) ? 1 : 0;
            e.oe  = (i == 0) ? 0 : disp_of(br);
            exp_q.push_back(e);
        end
        bus.in_enable = 1'b1;
        wait_lats(n - 1);
        r = $urandom_range(1, PIXEL_COUNT - 1);
        wait_clks(r);
        bus.in_enable = 1'b0;
        wait_lats(1);
        repeat (POST_BLANK + 8) @(negedge in_clk);
        #1;
        check("idle_pix_rdy", int'(bus.pix_rdy), 0);
        check("idle_led_oe", int'(bus.led_oe), 0);
        check("idle_no_clk", clk_cnt, 0);
        check("idle_no_oe", oe_cnt, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int snap_clk, snap_lat;
        in_nrst = 1'b0;
        bus.in_enable = 1'b0;
        bus.in_brightness = '0;
        model_row = ROW_COUNT - 1;
        repeat (3) @(negedge in_clk);
        #1;
        check("rst_pix_rdy", int'(bus.pix_rdy), 0);
        check("rst_led_clk", int'(bus.led_clk), 0);
        check("rst_led_lat", int'(bus.led_lat), 0);
        check("rst_led_oe", int'(bus.led_oe), 0);
        check("rst_frame_start", int'(bus.frame_start), 0);
        check("rst_led_row", int'(bus.led_row), ROW_COUNT - 1);
        in_nrst = 1'b1;

        // Reset in the middle of shifting a row
        pv_mode = 0;
        bus.in_enable = 1'b1;
        wait_clks(20);
        in_nrst = 1'b0;
        #1;
        check("mid_rst_pix_rdy", int'(bus.pix_rdy), 0);
        check("mid_rst_led_clk", int'(bus.led_clk), 0);
        check("mid_rst_led_lat", int'(bus.led_lat), 0);
        check("mid_rst_led_oe", int'(bus.led_oe), 0);
        check("mid_rst_frame_start", int'(bus.frame_start), 0);
        check("mid_rst_led_row", int'(bus.led_row), ROW_COUNT - 1);
        bus.in_enable = 1'b0;
        exp_q.delete();
        model_row = ROW_COUNT - 1;
        repeat (2) @(negedge in_clk);
        #1;
        in_nrst = 1'b1;
        snap_clk = clk_total;
        snap_lat = lat_total;
        repeat (30) @(negedge in_clk);
        #1;
        check("post_rst_no_clk", clk_total, snap_clk);
        check("post_rst_no_lat", lat_total, snap_lat);
        check("post_rst_pix_rdy", int'(bus.pix_rdy), 0);

        // Directed scenarios
        run_rows(2, 10, 0);
        run_rows(16, 0, 0);
        run_rows(3, 200, 0);
        run_rows(2, 10, 1);
        run_rows(1, 5, 0);

        // Randomized runs
        for (int k = 0; k < 6; k++) begin
            run_rows($urandom_range(1, 4), $urandom_range(0, 255), $urandom_range(0, 2));
        end

        check("frame_start_stray", fs_stray, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
